// File: rtl/i2s_rx_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_rx_sequencer_pkg                                                     |
// | Shared types and constants for the I2S receive sequencer.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package i2s_rx_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

  localparam int c_req_mixer = 0;
  localparam int c_req_debug = 1;

  // Ring slot that lies `back` frames behind the newest one; wr_ptr points at the next free slot.
  function automatic int unsigned ring_back(input int unsigned ptr,
                                            input int unsigned back,
                                            input int unsigned depth);
    return (ptr + 2 * depth - 1 - (back % depth)) % depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_rx_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_rx_sequencer_if                                                      |
// | Sample ring buffer write port and shared read-port arbitration bundle.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface i2s_rx_sequencer_if #(
  parameter int SAMPLE_BITS = 8,
  parameter int ADDR_W      = 4
);
  logic                     wr_en;
  logic                     wr_chan;
  logic [ADDR_W-1:0]        wr_addr;
  logic [SAMPLE_BITS-1:0]   wr_data;
  logic [ADDR_W:0]          fill_level;
  logic [1:0]               rd_req;
  logic [2*ADDR_W-1:0]      rd_age;
  logic [1:0]               rd_gnt;
  logic                     rd_err;
  logic [ADDR_W-1:0]        buf_rd_addr;

  modport master (
    output wr_en, wr_chan, wr_addr, wr_data, fill_level,
    output rd_gnt, rd_err, buf_rd_addr,
    input  rd_req, rd_age
  );

  modport slave (
    input  wr_en, wr_chan, wr_addr, wr_data, fill_level,
    input  rd_gnt, rd_err, buf_rd_addr,
    output rd_req, rd_age
  );
endinterface
`default_nettype wire

// File: rtl/i2s_rx_sequencer_rr_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter2                                                              |
// | Two-way round-robin arbiter with a registered one-hot grant.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_arbiter2
  import i2s_rx_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       valid
);

  logic r_prio;

  always_comb begin
    valid = |req;
    sel   = 1'(c_req_mixer);
    if (req == 2'b11) begin
      sel = r_prio;
    end else if (req[c_req_debug]) begin
      sel = 1'(c_req_debug);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'(c_req_mixer);
      gnt    <= 2'b00;
    end else begin
      gnt <= valid ? (2'b01 << sel) : 2'b00;
      if (valid) begin
        r_prio <= ~sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_rx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_rx_sequencer                                                         |
// | Master-mode I2S receiver feeding per-channel sample rings.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2s_rx_sequencer
  import i2s_rx_sequencer_pkg::*;
#(
  parameter int SAMPLE_BITS = 8,
  parameter int BCLK_DIV    = 4,
  parameter int DEPTH       = 10,
  parameter int ADDR_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sd_in,
  output logic                 sck_out,
  output logic                 ws_out,
  output logic                 busy,
  i2s_rx_sequencer_if.master   buf_if
);

  localparam int c_div_w = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int c_bit_w = (SAMPLE_BITS > 2) ? $clog2(SAMPLE_BITS) : 1;

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(BCLK_DIV / 2);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(SAMPLE_BITS - 1);
  localparam logic [ADDR_W-1:0]  c_ptr_last = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]    c_fill_max = (ADDR_W + 1)'(DEPTH);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_div_w-1:0]     r_div_cnt;
  logic [c_bit_w-1:0]     r_bit_cnt;
  logic                   r_ws;
  logic                   r_primed;
  logic [SAMPLE_BITS-2:0] r_shift;
  logic                   r_wr_en;
  chan_t                  r_wr_chan;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic [SAMPLE_BITS-1:0] r_wr_data;
  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W:0]        r_fill;
  logic [ADDR_W-1:0]      r_rd_addr;
  logic                   r_rd_err;

  logic                   w_running;
  logic                   w_slot_end;
  logic                   w_sample;
  logic                   w_complete;
  logic                   w_right_done;
  logic [SAMPLE_BITS-1:0] w_word;
  logic                   w_arb_sel;
  logic                   w_arb_valid;
  logic [ADDR_W-1:0]      w_age;
  logic [ADDR_W-1:0]      w_rd_addr;
  logic                   w_age_err;

  assign w_running  = (r_state != IDLE);
  assign w_slot_end = w_running && (r_div_cnt == c_div_last);
  assign w_sample   = w_running && (r_div_cnt == c_div_half);
  // Slot 0 carries the LSB of the word from the previous WS half; the very first one after IDLE has no word.
  assign w_complete   = w_sample && (r_bit_cnt == '0) && r_primed;
  assign w_right_done = w_complete && !r_ws;
  assign w_word       = {r_shift, sd_in};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (enable) w_state_nxt = RUN;
      RUN:     if (!enable) w_state_nxt = w_right_done ? IDLE : DRAIN;
      DRAIN:   if (w_right_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_ws      <= 1'b0;
      r_primed  <= 1'b0;
      r_shift   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == IDLE) begin
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_ws      <= 1'b0;
        r_primed  <= 1'b0;
      end else if (w_running) begin
        r_div_cnt <= w_slot_end ? '0 : r_div_cnt + 1'b1;
        if (w_slot_end) begin
          if (r_bit_cnt == c_bit_last) begin
            r_bit_cnt <= '0;
            r_ws      <= ~r_ws;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        if (w_sample) begin
          r_shift  <= w_word[SAMPLE_BITS-2:0];
          r_primed <= 1'b1;
        end
      end
    end
  end

  // Both words of a frame land at the same slot; the pointer advances once the right word is out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_chan <= CH_LEFT;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_ptr  <= '0;
      r_fill    <= '0;
    end else begin
      r_wr_en <= w_complete;
      if (w_complete) begin
        r_wr_chan <= r_ws ? CH_LEFT : CH_RIGHT;
        r_wr_data <= w_word;
        r_wr_addr <= r_wr_ptr;
      end
      if (r_wr_en && (r_wr_chan == CH_RIGHT)) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
        r_fill   <= (r_fill == c_fill_max) ? r_fill : r_fill + 1'b1;
      end
    end
  end

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (buf_if.rd_req),
    .gnt   (buf_if.rd_gnt),
    .sel   (w_arb_sel),
    .valid (w_arb_valid)
  );

  assign w_age     = w_arb_sel ? buf_if.rd_age[2*ADDR_W-1:ADDR_W] : buf_if.rd_age[ADDR_W-1:0];
  assign w_rd_addr = ADDR_W'(ring_back(32'(r_wr_ptr), 32'(w_age), DEPTH));
  assign w_age_err = ({1'b0, w_age} >= r_fill);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
      r_rd_err  <= 1'b0;
    end else if (w_arb_valid) begin
      r_rd_addr <= w_rd_addr;
      r_rd_err  <= w_age_err;
    end else begin
      r_rd_err  <= 1'b0;
    end
  end

  assign sck_out = w_running && (r_div_cnt >= c_div_half);
  assign ws_out  = r_ws;
  assign busy    = w_running;

  assign buf_if.wr_en       = r_wr_en;
  assign buf_if.wr_chan     = r_wr_chan;
  assign buf_if.wr_addr     = r_wr_addr;
  assign buf_if.wr_data     = r_wr_data;
  assign buf_if.fill_level  = r_fill;
  assign buf_if.rd_err      = r_rd_err;
  assign buf_if.buf_rd_addr = r_rd_addr;

endmodule
`default_nettype wire
